// File: rtl/axi_mem_pkg.sv
// Shared encodings and helpers for the AXI write-slave memory block.
// Consumers: axi_mem_wr_slave, axi_wr_next_addr.
package axi_mem_pkg;

  localparam int DEF_MEM_DEPTH = 128;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  typedef logic [1:0] wr_state_t;
  localparam wr_state_t ST_IDLE   = 2'd0;
  localparam wr_state_t ST_W_DATA = 2'd1;
  localparam wr_state_t ST_B_RESP = 2'd2;

  typedef struct packed {
    logic [3:0] id;
    logic [3:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } aw_req_t;

  function automatic logic [31:0] size_bytes(input logic [2:0] size);
    return 32'd1 << size;
  endfunction

  // INCR bursts start on the beat-size boundary; FIXED/WRAP use awaddr as given.
  function automatic logic [31:0] first_addr(input logic [31:0] addr, input logic [2:0] size,
                                             input logic [1:0] burst);
    if (burst == BURST_INCR) return addr & ~(size_bytes(size) - 32'd1);
    return addr;
  endfunction

  function automatic logic wrap_shape_ok(input logic [3:0] len, input logic [2:0] size,
                                         input logic [31:0] addr);
    logic [31:0] mask;
    mask = size_bytes(size) - 32'd1;
    return (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15) && ((addr & mask) == 32'd0);
  endfunction

endpackage

// File: rtl/axi_wr_next_addr.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
module axi_wr_next_addr
  import axi_mem_pkg::*;
(
  input  logic [31:0] cur_addr,
  input  logic [2:0]  size,
  input  logic [3:0]  len,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  logic [31:0] step, span, bound, inc;

  always_comb begin
    step  = size_bytes(size);
    span  = ({28'd0, len} + 32'd1) << size;
    // Wrap region is span-aligned, so the boundary can be rebuilt from any beat address.
    bound = cur_addr & ~(span - 32'd1);
    inc   = cur_addr + step;
    case (burst)
      BURST_INCR: next_addr = inc;
      BURST_WRAP: next_addr = (inc == bound + span) ? bound : inc;
      default:    next_addr = cur_addr;
    endcase
  end

endmodule

// File: rtl/axi_mem_wr_slave.sv
// AXI3-style single-outstanding write slave backed by a MEM_DEPTH x 32 memory.
// Define AXI_WR_WRAP_EN to accept WRAP bursts; otherwise WRAP is rejected with SLVERR.
module axi_mem_wr_slave
  import axi_mem_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [3:0]                   awid,
  input  logic [3:0]                   awlen,
  input  logic [2:0]                   awsize,
  input  logic [31:0]                  awaddr,
  input  logic [1:0]                   awburst,
  input  logic                         wvalid,
  output logic                         wready,
  input  logic [3:0]                   wid,
  input  logic [31:0]                  wdata,
  input  logic [3:0]                   wstrb,
  input  logic                         wlast,
  output logic                         bvalid,
  input  logic                         bready,
  output logic [3:0]                   bid,
  output logic [1:0]                   bresp,
  output logic [31:0]                  next_addrwr,
  input  logic [$clog2(MEM_DEPTH)-1:0] mem_rd_idx,
  output logic [31:0]                  mem_rd_data
);

  localparam int IDXW = $clog2(MEM_DEPTH);

  wr_state_t   state;
  aw_req_t     req;
  logic [3:0]  beat_cnt;
  logic        err, wr_off;
  logic [31:0] next_addr, word_idx;
  logic        aw_hs, w_hs, b_hs, last_beat, idx_ok, beat_err, aw_bad;
  logic [31:0] mem [MEM_DEPTH];

  assign aw_hs     = awvalid & awready;
  assign w_hs      = wvalid & wready;
  assign b_hs      = bvalid & bready;
  assign word_idx  = {2'b00, next_addrwr[31:2]};
  assign idx_ok    = word_idx < 32'(MEM_DEPTH);
  assign last_beat = beat_cnt == req.len;
  assign beat_err  = !idx_ok || (wid != req.id) || (wlast != last_beat);

  always_comb begin
    aw_bad = (awsize > 3'd2) || (awburst == 2'd3);
`ifdef AXI_WR_WRAP_EN
    if (awburst == BURST_WRAP && !wrap_shape_ok(awlen, awsize, awaddr)) aw_bad = 1'b1;
`else
    if (awburst == BURST_WRAP) aw_bad = 1'b1;
`endif
  end

  axi_wr_next_addr u_next_addr (
    .cur_addr (next_addrwr),
    .size     (req.size),
    .len      (req.len),
    .burst    (req.burst),
    .next_addr(next_addr)
  );

  // next_addrwr doubles as the address register for the beat currently expected.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      awready     <= 1'b0;
      wready      <= 1'b0;
      bvalid      <= 1'b0;
      bid         <= 4'd0;
      bresp       <= RESP_OKAY;
      next_addrwr <= 32'd0;
      req         <= '0;
      beat_cnt    <= 4'd0;
      err         <= 1'b0;
      wr_off      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          awready <= 1'b1;
          if (aw_hs) begin
            req         <= '{id: awid, len: awlen, size: awsize, burst: awburst};
            next_addrwr <= first_addr(awaddr, awsize, awburst);
            beat_cnt    <= 4'd0;
            err         <= aw_bad;
            wr_off      <= aw_bad;
            awready     <= 1'b0;
            wready      <= 1'b1;
            state       <= ST_W_DATA;
          end
        end
        ST_W_DATA: begin
          if (w_hs) begin
            next_addrwr <= next_addr;
            beat_cnt    <= beat_cnt + 4'd1;
            err         <= err | beat_err;
            if (last_beat) begin
              wready <= 1'b0;
              bvalid <= 1'b1;
              bid    <= req.id;
              bresp  <= (err | beat_err) ? RESP_SLVERR : RESP_OKAY;
              state  <= ST_B_RESP;
            end
          end
        end
        ST_B_RESP: begin
          if (b_hs) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory is deliberately outside the reset domain so contents survive resetn.
  always_ff @(posedge clk) begin
    if (resetn && w_hs && !wr_off && idx_ok) begin
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[word_idx[IDXW-1:0]][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign mem_rd_data = mem[mem_rd_idx];

endmodule

// File: tb/tb_axi_mem_wr_slave.sv
// Randomized self-checking bench for axi_mem_wr_slave against a burst-level model.
module tb_axi_mem_wr_slave;

  localparam int DEPTH = 128;
`ifdef AXI_WR_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0, resetn = 1'b0;
  logic        awvalid = 1'b0, awready;
  logic [3:0]  awid = '0, awlen = '0;
  logic [2:0]  awsize = '0;
  logic [31:0] awaddr = '0;
  logic [1:0]  awburst = '0;
  logic        wvalid = 1'b0, wready, wlast = 1'b0;
  logic [3:0]  wid = '0, wstrb = '0;
  logic [31:0] wdata = '0;
  logic        bvalid, bready = 1'b0;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic [31:0] next_addrwr, mem_rd_data;
  logic [6:0]  mem_rd_idx = '0;

  always #5 clk = ~clk;

  axi_mem_wr_slave #(.MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awlen(awlen), .awsize(awsize),
    .awaddr(awaddr), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .next_addrwr(next_addrwr), .mem_rd_idx(mem_rd_idx), .mem_rd_data(mem_rd_data)
  );

  // model state and expectations
  logic [31:0] model_mem [DEPTH];
  bit          known [DEPTH];
  logic        exp_awready = 0, exp_wready = 0, exp_bvalid = 0;
  logic [3:0]  exp_bid = 0;
  logic [1:0]  exp_bresp = 0;
  logic [31:0] exp_next = 0;
  bit          chk_on = 0, chk_b = 0, chk_next = 0;
  int          n_chk = 0, n_err = 0, scan = 0;

  logic [31:0] bd [16];
  logic [3:0]  bs [16], bw [16];
  logic        bl [16];
  logic [1:0]  rsp_bresp;
  logic [3:0]  rsp_bid;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, got, expv, $time);
    end
  endtask

  function automatic logic [31:0] addr_of(input logic [1:0] bt, input logic [31:0] a,
                                          input logic [3:0] len, input logic [2:0] size, input int i);
    logic [31:0] sz, tot, bnd;
    sz  = 32'd1 << size;
    tot = (32'(len) + 32'd1) * sz;
    bnd = a & ~(tot - 32'd1);
    case (bt)
      2'd0:    return a;
      2'd2:    return bnd + ((a - bnd) + 32'(i) * sz) % tot;
      default: return (a & ~(sz - 32'd1)) + 32'(i) * sz;
    endcase
  endfunction

  function automatic bit wrap_shape_bad(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size);
    logic [31:0] sz;
    sz = 32'd1 << size;
    return !(len == 1 || len == 3 || len == 7 || len == 15) || (a % sz != 0);
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("awready", 32'(awready), 32'(exp_awready));
      chk("wready", 32'(wready), 32'(exp_wready));
      chk("bvalid", 32'(bvalid), 32'(exp_bvalid));
      if (chk_b) begin
        chk("bid", 32'(bid), 32'(exp_bid));
        chk("bresp", 32'(bresp), 32'(exp_bresp));
      end
      if (chk_next) chk("next_addrwr", next_addrwr, exp_next);
      mem_rd_idx = 7'(scan);
      #1;
      if (known[scan]) chk("mem", mem_rd_data, model_mem[scan]);
      scan = (scan + 1) % DEPTH;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_beats(input logic [3:0] id, input logic [3:0] len, input logic [31:0] base);
    for (int i = 0; i < 16; i++) begin
      bd[i] = base + 32'(i); bs[i] = 4'hF; bw[i] = id; bl[i] = (i == int'(len));
    end
  endtask

  task automatic run_burst(input logic [3:0] id, input logic [3:0] len, input logic [2:0] size,
                           input logic [31:0] addr, input logic [1:0] bt, input int bdelay,
                           input int abort_at, input int max_gap);
    bit bad, err, no_next;
    logic [31:0] a, idx;
    no_next = (bt == 2'd3) || (bt == 2'd2 && wrap_shape_bad(addr, len, size));
    bad = (size > 3'd2) || (bt == 2'd3) || (bt == 2'd2 && (!WRAP_EN || wrap_shape_bad(addr, len, size)));
    err = bad;
    awvalid = 1; awid = id; awlen = len; awsize = size; awaddr = addr; awburst = bt;
    cyc();
    awvalid = 0;
    exp_awready = 0; exp_wready = 1;
    exp_next = addr_of(bt, addr, len, size, 0); chk_next = !no_next;
    for (int i = 0; i <= int'(len); i++) begin
      if (abort_at == i) begin
        resetn = 0;
        cyc();
        exp_wready = 0; exp_awready = 0; exp_bvalid = 0;
        exp_bid = 0; exp_bresp = 0; chk_b = 1; exp_next = 0; chk_next = 1;
        repeat (2) cyc();
        resetn = 1;
        cyc();
        exp_awready = 1; chk_b = 0; chk_next = 0;
        return;
      end
      repeat ($urandom_range(0, max_gap)) cyc();
      wvalid = 1; wid = bw[i]; wdata = bd[i]; wstrb = bs[i]; wlast = bl[i];
      cyc();
      wvalid = 0; wlast = 0;
      a = addr_of(bt, addr, len, size, i);
      idx = a >> 2;
      if (idx >= 32'(DEPTH) || bw[i] != id || bl[i] != (i == int'(len))) err = 1;
      if (!bad && idx < 32'(DEPTH)) begin
        for (int b = 0; b < 4; b++)
          if (bs[i][b]) model_mem[idx][8*b +: 8] = bd[i][8*b +: 8];
      end
      exp_next = addr_of(bt, addr, len, size, i + 1);
      if (i == int'(len)) begin
        exp_wready = 0; exp_bvalid = 1; exp_bid = id; exp_bresp = err ? 2'd2 : 2'd0;
        chk_b = 1; chk_next = 0;
        rsp_bresp = bresp; rsp_bid = bid;
      end
    end
    repeat (bdelay) cyc();
    bready = 1;
    cyc();
    bready = 0;
    exp_bvalid = 0; exp_awready = 1; chk_b = 0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) known[i] = 0;
    cyc();
    chk_on = 1; chk_b = 1; chk_next = 1;
    repeat (2) cyc();
    resetn = 1;
    cyc();
    exp_awready = 1; chk_b = 0; chk_next = 0;

    chk("addr_of_wrap", addr_of(2'd2, 32'h8, 4'd3, 3'd2, 2), 32'h0);
    chk("addr_of_incr", addr_of(2'd1, 32'h13, 4'd3, 3'd2, 1), 32'h14);

    // fill the whole memory with a known pattern
    for (int b = 0; b < DEPTH / 16; b++) begin
      set_beats(4'd0, 4'd15, 32'hA500_0000 + 32'(b * 16));
      run_burst(4'd0, 4'd15, 3'd2, 32'(b * 64), 2'd1, 0, -1, 1);
      for (int i = 0; i < 16; i++) known[b * 16 + i] = 1;
    end

    set_beats(4'd5, 4'd3, 32'd1);
    run_burst(4'd5, 4'd3, 3'd2, 32'h10, 2'd1, 0, -1, 0);
    for (int i = 0; i < 4; i++) chk("incr_word", model_mem[4 + i], 32'(i + 1));
    chk("incr_bresp", 32'(rsp_bresp), 32'd0);
    chk("incr_bid", 32'(rsp_bid), 32'd5);

    set_beats(4'd6, 4'd3, 32'hC0);
    run_burst(4'd6, 4'd3, 3'd2, 32'h08, 2'd2, 1, -1, 0);
`ifdef AXI_WR_WRAP_EN
    chk("wrap_w2", model_mem[2], 32'hC0);
    chk("wrap_w0", model_mem[0], 32'hC2);
    chk("wrap_bresp", 32'(rsp_bresp), 32'd0);
`else
    chk("wrap_w2", model_mem[2], 32'hA500_0002);
    chk("wrap_w0", model_mem[0], 32'hA500_0000);
    chk("wrap_bresp", 32'(rsp_bresp), 32'd2);
`endif

    set_beats(4'd2, 4'd2, 32'h0);
    bd[0] = 32'h1111_1111; bd[1] = 32'h2222_2222; bd[2] = 32'h3333_3333;
    bs[0] = 4'h1; bs[1] = 4'h2; bs[2] = 4'h4;
    run_burst(4'd2, 4'd2, 3'd2, 32'h20, 2'd0, 0, -1, 1);
    chk("fixed_word", model_mem[8], 32'hA533_2211);
    chk("fixed_bresp", 32'(rsp_bresp), 32'd0);

    set_beats(4'd9, 4'd1, 32'hDD00_0001);
    run_burst(4'd9, 4'd1, 3'd2, 32'((DEPTH - 1) * 4), 2'd1, 0, -1, 0);
    chk("edge_word", model_mem[DEPTH - 1], 32'hDD00_0001);
    chk("edge_bresp", 32'(rsp_bresp), 32'd2);

    set_beats(4'd3, 4'd3, 32'hBB00_0000);
    bw[1] = 4'd4;
    run_burst(4'd3, 4'd3, 3'd2, 32'h30, 2'd1, 5, -1, 0);
    chk("wid_bresp", 32'(rsp_bresp), 32'd2);

    set_beats(4'd7, 4'd3, 32'hEE00_0000);
    run_burst(4'd7, 4'd3, 3'd2, 32'h40, 2'd1, 0, 2, 0);
    chk("abort_w16", model_mem[16], 32'hEE00_0000);
    chk("abort_w17", model_mem[17], 32'hEE00_0001);
    chk("abort_w18", model_mem[18], 32'hA500_0012);

    for (int t = 0; t < 60; t++) begin
      logic [3:0] id, len;
      logic [2:0] size;
      logic [1:0] bt;
      logic [31:0] addr;
      id = 4'($urandom);
      bt = 2'($urandom_range(0, 3));
      if (bt == 2'd3 && $urandom_range(0, 1) == 0) bt = 2'd1;
      size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      len = 4'($urandom);
      if (bt == 2'd2 && $urandom_range(0, 3) != 0) len = 4'((2 << $urandom_range(0, 3)) - 1);
      addr = ($urandom_range(0, 3) == 0) ? 32'(DEPTH * 4 - 8 + $urandom_range(0, 16))
                                         : 32'($urandom_range(0, DEPTH * 4 - 1));
      if (bt == 2'd2 && $urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << size) - 32'd1);
      for (int i = 0; i < 16; i++) begin
        bd[i] = $urandom; bs[i] = 4'($urandom);
        bw[i] = ($urandom_range(0, 9) == 0) ? 4'($urandom) : id;
        bl[i] = (i == int'(len)) ^ ($urandom_range(0, 11) == 0);
      end
      run_burst(id, len, size, addr, bt, $urandom_range(0, 3), -1, 2);
    end

    repeat (DEPTH + 4) cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
